// File: rtl/regfile_bus_pkg.sv
// rtl/regfile_bus_pkg.sv - shared constants and helpers for the bus register file
package regfile_bus_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;
  localparam int unsigned REG_SP = 6;
  localparam int unsigned REG_PC = 7;
  localparam logic [15:0] PC_RESET_DEFAULT = 16'h0000;

  // True when more than one select bit is set; clearing the lowest set bit leaves a remainder.
  function automatic logic onehot_violation(input logic [7:0] vec);
    return (vec & (vec - 8'd1)) != 8'd0;
  endfunction

endpackage

// File: rtl/regfile_bus_cell.sv
// rtl/regfile_bus_cell.sv - single register with async reset value and load enable
module regfile_bus_cell #(
  parameter int unsigned WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_bus.sv
// rtl/regfile_bus.sv - 8-entry bus register file, r7 is the PC (optional checks: REGFILE_BUS_CHECK_EN)
module regfile_bus
  import regfile_bus_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned NREGS = 8,
  parameter logic [WIDTH-1:0] PC_RESET = PC_RESET_DEFAULT[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       regOes,
  input  logic [7:0]       regLoads,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pc_inc,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_en,
  output logic [WIDTH-1:0] pc,
  output logic             bus_err
);

  logic [WIDTH-1:0] regs [NREGS];

  for (genvar i = 0; i < REG_PC; i++) begin : g_cell
    regfile_bus_cell #(
      .WIDTH     (WIDTH),
      .RESET_VAL ('0)
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .load  (regLoads[i]),
      .d     (data_in),
      .q     (regs[i])
    );
  end

  // A load to r7 is a jump and always beats the sequencer's increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs[REG_PC] <= PC_RESET;
    end else if (regLoads[REG_PC]) begin
      regs[REG_PC] <= data_in;
    end else if (pc_inc) begin
      regs[REG_PC] <= regs[REG_PC] + WIDTH'(1);
    end
  end

  always_comb begin
    data_out = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (regOes[i]) data_out = data_out | regs[i];
    end
  end

  assign data_out_en = |regOes;
  assign pc = regs[REG_PC];

`ifdef REGFILE_BUS_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_err <= 1'b0;
    end else if (onehot_violation(regOes) || (pc_inc && regLoads[REG_PC])) begin
      bus_err <= 1'b1;
    end
  end
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_bus.sv
// tb/tb_regfile_bus.sv - directed self-checking bench for regfile_bus
module tb_regfile_bus;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  regOes = 8'h00;
  logic [7:0]  regLoads = 8'h00;
  logic [15:0] data_in = 16'h0000;
  logic        pc_inc = 1'b0;
  logic [15:0] data_out;
  logic        data_out_en;
  logic [15:0] pc;
  logic        bus_err;

  int tests = 0;
  int failed = 0;

`ifdef REGFILE_BUS_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  regfile_bus dut (
    .clk         (clk),
    .reset       (reset),
    .regOes      (regOes),
    .regLoads    (regLoads),
    .data_in     (data_in),
    .pc_inc      (pc_inc),
    .data_out    (data_out),
    .data_out_en (data_out_en),
    .pc          (pc),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    regLoads = 8'h80;
    data_in = 16'h1234;
    step();
    regLoads = 8'h00;
    check("pre_reset_pc", pc, 16'h1234);

    // Reset mid-cycle overrides pending loads
    @(negedge clk);
    regLoads = 8'hFF;
    data_in = 16'hBEEF;
    reset = 1'b1;
    #1;
    check("reset_pc", pc, 16'h0000);
    check("reset_bus_err", {15'd0, bus_err}, 16'h0000);
    step();
    check("reset_hold_pc", pc, 16'h0000);
    reset = 1'b0;
    regLoads = 8'h00;
    regOes = 8'h01;
    step();
    check("reset_r0", data_out, 16'h0000);
    check("reset_r0_en", {15'd0, data_out_en}, 16'h0001);

    // Load and read back r3
    regOes = 8'h00;
    regLoads = 8'h08;
    data_in = 16'h1234;
    step();
    regLoads = 8'h00;
    regOes = 8'h08;
    #1;
    check("r3_read", data_out, 16'h1234);
    check("r3_read_en", {15'd0, data_out_en}, 16'h0001);
    regOes = 8'h00;
    #1;
    check("idle_out", data_out, 16'h0000);
    check("idle_en", {15'd0, data_out_en}, 16'h0000);

    // Read-during-write on r2: no bypass
    regLoads = 8'h04;
    data_in = 16'h0005;
    step();
    regOes = 8'h04;
    data_in = 16'h0006;
    #1;
    check("rdw_before", data_out, 16'h0005);
    step();
    check("rdw_after", data_out, 16'h0006);
    regLoads = 8'h00;

    // PC increment and wrap; r2 untouched
    regLoads = 8'h80;
    data_in = 16'hFFFE;
    step();
    regLoads = 8'h00;
    pc_inc = 1'b1;
    step();
    check("pc_inc1", pc, 16'hFFFF);
    step();
    check("pc_wrap", pc, 16'h0000);
    check("pc_inc_r2", data_out, 16'h0006);
    check("pc_inc_noerr", {15'd0, bus_err}, 16'h0000);

    // Jump beats increment
    regOes = 8'h00;
    regLoads = 8'h80;
    data_in = 16'h0100;
    step();
    check("jump_wins", pc, 16'h0100);
    check("jump_conflict_err", {15'd0, bus_err}, {15'd0, CHECK_EN});
    pc_inc = 1'b0;
    regLoads = 8'h00;

    // Broadcast to r0..r6 leaves r7
    regLoads = 8'h7F;
    data_in = 16'hA5A5;
    step();
    regLoads = 8'h00;
    check("bcast_pc", pc, 16'h0100);
    for (int i = 0; i < 7; i++) begin
      regOes = 8'h01 << i;
      #1;
      check($sformatf("bcast_r%0d", i), data_out, 16'hA5A5);
    end

    // Contention: OR of r0 and r7
    regOes = 8'h81;
    #1;
    check("contend_out", data_out, 16'hA5A5);
    check("contend_en", {15'd0, data_out_en}, 16'h0001);
    step();
    check("contend_err", {15'd0, bus_err}, {15'd0, CHECK_EN});
    regOes = 8'h00;

    // Sticky error until reset
    for (int i = 0; i < 10; i++) step();
    check("sticky_err", {15'd0, bus_err}, {15'd0, CHECK_EN});
    reset = 1'b1;
    #1;
    check("clear_err", {15'd0, bus_err}, 16'h0000);
    check("clear_pc", pc, 16'h0000);
    step();
    reset = 1'b0;
    regOes = 8'h08;
    #1;
    check("clear_r3", data_out, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
